// File: rtl/mem_req_ctrl.sv
// Request sequencer feeding a synchronous memory with a fixed pipelined read latency.
// Define MEMCTL_PIPE_EN to replace the blocking FSM with a one-request-per-cycle issue path.
module mem_req_ctrl #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RD_LAT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] mem_addr_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic [ADDR_W-1:0] mem_addr_wr,
  output logic [DATA_W-1:0] mem_data_wr,
  output logic              mem_wren
);

  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic [ADDR_W-1:0] addr_rd_q,   addr_rd_d;
  logic [ADDR_W-1:0] addr_wr_q,   addr_wr_d;
  logic [DATA_W-1:0] data_wr_q,   data_wr_d;
  logic              wren_q,      wren_d;

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign mem_addr_rd = addr_rd_q;
  assign mem_addr_wr = addr_wr_q;
  assign mem_data_wr = data_wr_q;
  assign mem_wren    = wren_q;

`ifdef MEMCTL_PIPE_EN
  logic [RD_LAT:0] vld_sr_q, vld_sr_d;
  logic            accept;

  assign req_ready = !rst;
  assign accept    = req_valid && !rst;

  always_comb begin
    addr_rd_d   = addr_rd_q;
    addr_wr_d   = addr_wr_q;
    data_wr_d   = data_wr_q;
    wren_d      = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = vld_sr_q[RD_LAT];
    if (vld_sr_q[RD_LAT]) begin
      rsp_data_d = mem_q;
    end
    // Each cycle shifts in one token: 1 for an accepted read, 0 otherwise.
    vld_sr_d[0] = accept && !req_we;
    for (int unsigned i = 1; i <= RD_LAT; i++) begin
      vld_sr_d[i] = vld_sr_q[i-1];
    end
    if (accept) begin
      if (req_we) begin
        addr_wr_d = req_addr;
        data_wr_d = req_wdata;
        wren_d    = 1'b1;
      end else begin
        addr_rd_d = req_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_rd_q   <= '0;
      addr_wr_q   <= '0;
      data_wr_q   <= '0;
      wren_q      <= 1'b0;
    end else begin
      vld_sr_q    <= vld_sr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_rd_q   <= addr_rd_d;
      addr_wr_q   <= addr_wr_d;
      data_wr_q   <= data_wr_d;
      wren_q      <= wren_d;
    end
  end
`else
  localparam int unsigned CNT_W = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ_WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  assign req_ready = (state_q == IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_rd_d   = addr_rd_q;
    addr_wr_d   = addr_wr_q;
    data_wr_d   = data_wr_q;
    wren_d      = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          if (req_we) begin
            addr_wr_d = req_addr;
            data_wr_d = req_wdata;
            wren_d    = 1'b1;
            state_d   = WRITE;
          end else begin
            addr_rd_d = req_addr;
            cnt_d     = '0;
            state_d   = READ_WAIT;
          end
        end
      end
      WRITE: state_d = IDLE;
      READ_WAIT: begin
        if (cnt_q == CNT_W'(RD_LAT)) begin
          rsp_data_d  = mem_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_rd_q   <= '0;
      addr_wr_q   <= '0;
      data_wr_q   <= '0;
      wren_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      addr_rd_q   <= addr_rd_d;
      addr_wr_q   <= addr_wr_d;
      data_wr_q   <= data_wr_d;
      wren_q      <= wren_d;
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Scoreboard bench for mem_req_ctrl: a 3-stage pipelined memory model plus a flat reference memory.
// Covers the blocking FSM by default and the pipelined path when MEMCTL_PIPE_EN is defined.
module tb_mem_req_ctrl;
  localparam int unsigned AW  = 14;
  localparam int unsigned DW  = 8;
  localparam int unsigned LAT = 3;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] mem_addr_rd;
  logic [DW-1:0] mem_q;
  logic [AW-1:0] mem_addr_wr;
  logic [DW-1:0] mem_data_wr;
  logic          mem_wren;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] init_mem [0:DEPTH-1];
  logic [DW-1:0] bram     [0:DEPTH-1];
  logic [DW-1:0] ref_mem  [0:DEPTH-1];
  logic [DW-1:0] st       [0:LAT-1];
  bit            loaded = 1'b0;

  logic [DW-1:0] exp_data [$];
  int            exp_cyc  [$];

  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(LAT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_addr_rd (mem_addr_rd),
    .mem_q       (mem_q),
    .mem_addr_wr (mem_addr_wr),
    .mem_data_wr (mem_data_wr),
    .mem_wren    (mem_wren)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: write commits at the edge wren is seen; q lags the sampled addr_rd by LAT edges.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < int'(DEPTH); i++) bram[i] <= init_mem[i];
      loaded <= 1'b1;
    end else if (mem_wren) begin
      bram[mem_addr_wr] <= mem_data_wr;
    end
    st[0] <= bram[mem_addr_rd];
    for (int i = 1; i < int'(LAT); i++) st[i] <= st[i-1];
  end
  assign mem_q = st[LAT-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_data.size() == 0) begin
        check("spurious_rsp", {31'd0, rsp_valid}, 32'd0);
      end else begin
        check("rsp_data", {24'd0, rsp_data}, {24'd0, exp_data.pop_front()});
        check("rsp_cycle", cyc, exp_cyc.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge.
  task automatic issue(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    #1;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: waited %0d cycles, required < 50", n);
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (we) begin
      ref_mem[a] = d;
      check("wren", {31'd0, mem_wren}, 32'd1);
      check("addr_wr", {18'd0, mem_addr_wr}, {18'd0, a});
      check("data_wr", {24'd0, mem_data_wr}, {24'd0, d});
    end else begin
      exp_data.push_back(ref_mem[a]);
      exp_cyc.push_back(cyc + int'(LAT) + 1);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [AW-1:0] pool [8] = '{14'h0010, 14'h3FFF, 14'h0000, 14'h0001,
                              14'h0123, 14'h2000, 14'h1FFF, 14'h0002};

  initial begin
    int n;
    for (int i = 0; i < int'(DEPTH); i++) init_mem[i] = 8'($urandom);
    init_mem[0] = 8'h11;
    init_mem[1] = 8'hA1;
    init_mem[2] = 8'hA2;
    init_mem[3] = 8'hA3;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = init_mem[i];

    rst       = 1'b1;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 14'h0123;
    req_wdata = 8'hEE;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rst_ready", {31'd0, req_ready}, 32'd0);
      check("rst_wren", {31'd0, mem_wren}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    end
    check("rst_addr_rd", {18'd0, mem_addr_rd}, 32'd0);
    check("rst_addr_wr", {18'd0, mem_addr_wr}, 32'd0);
    check("rst_rsp_data", {24'd0, rsp_data}, 32'd0);
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

`ifdef MEMCTL_PIPE_EN
    issue(1'b0, 14'h0001, 8'h00);
    issue(1'b0, 14'h0002, 8'h00);
    issue(1'b0, 14'h0003, 8'h00);
    idle(8);
    issue(1'b1, 14'h0020, 8'h77);
    issue(1'b0, 14'h0020, 8'h00);
    idle(8);
`else
    issue(1'b1, 14'h0010, 8'h5A);
    check("ready_in_write", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("wren_one_cycle", {31'd0, mem_wren}, 32'd0);
    issue(1'b0, 14'h0010, 8'h00);
    for (int k = 0; k <= int'(LAT); k++) begin
      check("addr_rd_hold", {18'd0, mem_addr_rd}, 32'h0010);
      @(negedge clk);
    end
    idle(3);
    issue(1'b1, 14'h3FFF, 8'hC3);
    issue(1'b0, 14'h3FFF, 8'h00);
    issue(1'b0, 14'h0000, 8'h00);
    idle(8);
`endif

    // Reset two cycles after a read is accepted: that read must never answer.
    issue(1'b0, 14'h0010, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    exp_data.delete();
    exp_cyc.delete();
    idle(2);
    rst = 1'b0;
    idle(8);
    issue(1'b0, 14'h0010, 8'h00);
    idle(8);

    for (int k = 0; k < 80; k++) begin
      issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], 8'($urandom));
      idle(int'($urandom_range(0, 2)));
    end

    n = 0;
    while (exp_data.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_data.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
